// File: rtl/alu_pkg.sv
// Shared op-codes, op-class decode and engine state encoding for the
// alu_muldiv execute unit.
package alu_pkg;

   localparam logic [4:0] OP_ADD   = 5'h00;
   localparam logic [4:0] OP_SUB   = 5'h01;
   localparam logic [4:0] OP_SLT   = 5'h02;
   localparam logic [4:0] OP_AND   = 5'h03;
   localparam logic [4:0] OP_LUI   = 5'h04;
   localparam logic [4:0] OP_NOR   = 5'h05;
   localparam logic [4:0] OP_OR    = 5'h06;
   localparam logic [4:0] OP_XOR   = 5'h07;
   localparam logic [4:0] OP_SLL   = 5'h08;
   localparam logic [4:0] OP_SRA   = 5'h09;
   localparam logic [4:0] OP_SRL   = 5'h0A;
   localparam logic [4:0] OP_SLTU  = 5'h0B;
   localparam logic [4:0] OP_MULT  = 5'h0C;
   localparam logic [4:0] OP_MULTU = 5'h0D;
   localparam logic [4:0] OP_DIV   = 5'h0E;
   localparam logic [4:0] OP_DIVU  = 5'h0F;
   localparam logic [4:0] OP_MFHI  = 5'h10;
   localparam logic [4:0] OP_MFLO  = 5'h11;
   localparam logic [4:0] OP_MTHI  = 5'h12;
   localparam logic [4:0] OP_MTLO  = 5'h13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } md_state_t;

   typedef struct packed {
      logic is_md;
      logic is_mf;
      logic is_mt;
   } op_class_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      op_class_t c;
      c.is_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
      c.is_mf = (op == OP_MFHI) || (op == OP_MFLO);
      c.is_mt = (op == OP_MTHI) || (op == OP_MTLO);
      return c;
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair.
// Signed ops run on magnitudes; the sign is restored in the FIX cycle.
module muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             md_go_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   input  logic [4:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam int CW = $clog2(WIDTH) + 1;

   md_state_t        state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             is_div_q;
   logic             neg_q;
   logic             rem_neg_q;
   logic             dz_q;
   logic             busy_q;
   logic             done_q;

   logic             a_neg_s;
   logic             b_neg_s;
   logic [WIDTH-1:0] a_mag_s;
   logic [WIDTH-1:0] b_mag_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_sh_s;
   logic [WIDTH+1:0] div_trial_s;
   logic [WIDTH:0]   acc_d;
   logic [WIDTH-1:0] sr_d;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0] hi_fix_s;
   logic [WIDTH-1:0] lo_fix_s;

   // Operand magnitudes, one iteration step, and the final sign fix-up
   always_comb begin
      a_neg_s     = ((op_i == OP_MULT) || (op_i == OP_DIV)) && a_i[WIDTH-1];
      b_neg_s     = ((op_i == OP_MULT) || (op_i == OP_DIV)) && b_i[WIDTH-1];
      a_mag_s     = a_neg_s ? -a_i : a_i;
      b_mag_s     = b_neg_s ? -b_i : b_i;
      mul_sum_s   = acc_q + (sr_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      div_sh_s    = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
      div_trial_s = {1'b0, div_sh_s} - {2'b00, opnd_q};
      if (is_div_q) begin
         acc_d = div_trial_s[WIDTH+1] ? div_sh_s : div_trial_s[WIDTH:0];
         sr_d  = {sr_q[WIDTH-2:0], ~div_trial_s[WIDTH+1]};
      end else begin
         acc_d = {1'b0, mul_sum_s[WIDTH:1]};
         sr_d  = {mul_sum_s[0], sr_q[WIDTH-1:1]};
      end
      prod_s = neg_q ? -{acc_q[WIDTH-1:0], sr_q} : {acc_q[WIDTH-1:0], sr_q};
      if (is_div_q) begin
         // Remainder already equals |dividend| when dividing by zero, so only LO needs forcing
         hi_fix_s = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         lo_fix_s = dz_q ? {WIDTH{1'b1}} : (neg_q ? -sr_q : sr_q);
      end else begin
         hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
         lo_fix_s = prod_s[WIDTH-1:0];
      end
   end

   // Engine FSM, datapath registers and HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= {CW{1'b0}};
         acc_q     <= {(WIDTH+1){1'b0}};
         sr_q      <= {WIDTH{1'b0}};
         opnd_q    <= {WIDTH{1'b0}};
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               cnt_q  <= {CW{1'b0}};
               if (md_go_i) begin
                  is_div_q  <= (op_i == OP_DIV) || (op_i == OP_DIVU);
                  neg_q     <= a_neg_s ^ b_neg_s;
                  rem_neg_q <= a_neg_s;
                  dz_q      <= (b_i == {WIDTH{1'b0}});
                  acc_q     <= {(WIDTH+1){1'b0}};
                  sr_q      <= a_mag_s;
                  opnd_q    <= b_mag_s;
                  busy_q    <= 1'b1;
                  state_q   <= CALC;
               end else if (mthi_i) begin
                  hi_q <= a_i;
               end else if (mtlo_i) begin
                  lo_q <= a_i;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               sr_q  <= sr_d;
               cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == CW'(WIDTH - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= FIX;
               end
            end
            FIX: begin
               hi_q    <= hi_fix_s;
               lo_q    <= lo_fix_s;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               cnt_q   <= {CW{1'b0}};
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage execute unit: single-cycle ALU plus the iterative mul/div engine,
// with a stall to the control unit while the engine is in flight.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic             stall
);
   op_class_t        cls_s;
   logic             md_go_s;
   logic             mthi_s;
   logic             mtlo_s;
   logic             busy_s;
   logic             done_s;
   logic             ovf_s;
   logic [WIDTH-1:0] hi_s;
   logic [WIDTH-1:0] lo_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] res_s;
   logic [SHW-1:0]   sh_s;

   // Issue qualification, ALU operations and result mux
   always_comb begin
      cls_s   = op_class(op);
      md_go_s = in_valid && !busy_s && cls_s.is_md;
      mthi_s  = in_valid && !busy_s && (op == OP_MTHI);
      mtlo_s  = in_valid && !busy_s && (op == OP_MTLO);
      sum_s   = a + b;
      diff_s  = a - b;
      sh_s    = a[SHW-1:0];
      ovf_s   = 1'b0;
      res_s   = {WIDTH{1'b0}};
      case (op)
         OP_ADD: begin
            res_s = sum_s;
            ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_s = diff_s;
            ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_AND:  res_s = a & b;
         OP_LUI:  res_s = b << 5'd16;
         OP_NOR:  res_s = ~(a | b);
         OP_OR:   res_s = a | b;
         OP_XOR:  res_s = a ^ b;
         OP_SLL:  res_s = b << sh_s;
         OP_SRA:  res_s = $signed(b) >>> sh_s;
         OP_SRL:  res_s = b >> sh_s;
         OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_MFHI: res_s = hi_s;
         OP_MFLO: res_s = lo_s;
         default: res_s = {WIDTH{1'b0}};
      endcase
   end

   muldiv_seq #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .md_go_i (md_go_s),
      .mthi_i  (mthi_s),
      .mtlo_i  (mtlo_s),
      .op_i    (op),
      .a_i     (a),
      .b_i     (b),
      .hi_o    (hi_s),
      .lo_o    (lo_s),
      .busy_o  (busy_s),
      .done_o  (done_s)
   );

   assign result   = res_s;
   assign zero     = (res_s == {WIDTH{1'b0}});
   assign overflow = ovf_s;
   assign busy     = busy_s;
   assign done     = done_s;
   assign in_ready = !busy_s;
   assign stall    = busy_s && (cls_s.is_md || cls_s.is_mf || cls_s.is_mt);

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised self-checking bench for alu_muldiv (WIDTH=32) against an
// arithmetic reference model.
module tb_alu_muldiv;
   localparam int W = 32;
   localparam logic [4:0] C_ADD = 5'h00, C_SUB = 5'h01, C_SLT = 5'h02, C_AND = 5'h03;
   localparam logic [4:0] C_LUI = 5'h04, C_NOR = 5'h05, C_OR = 5'h06, C_XOR = 5'h07;
   localparam logic [4:0] C_SLL = 5'h08, C_SRA = 5'h09, C_SRL = 5'h0A, C_SLTU = 5'h0B;
   localparam logic [4:0] C_MULT = 5'h0C, C_MULTU = 5'h0D, C_DIV = 5'h0E, C_DIVU = 5'h0F;
   localparam logic [4:0] C_MFHI = 5'h10, C_MFLO = 5'h11, C_MTHI = 5'h12, C_MTLO = 5'h13;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  op;
   logic [31:0] a, b, result;
   logic        in_valid, in_ready, zero, overflow, busy, done, stall;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] m_hi, m_lo;

   alu_muldiv dut (
      .clk(clk), .rst_n(rst_n), .op(op), .a(a), .b(b), .in_valid(in_valid),
      .in_ready(in_ready), .result(result), .zero(zero), .overflow(overflow),
      .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] alu_ref(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, s;
      logic [31:0] r;
      logic ov;
      int sh;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sh = int'(x[4:0]);
      r  = 32'h0;
      ov = 1'b0;
      case (f)
         C_ADD:   begin s = sx + sy; r = s[31:0]; ov = (s != longint'($signed(r))); end
         C_SUB:   begin s = sx - sy; r = s[31:0]; ov = (s != longint'($signed(r))); end
         C_SLT:   r = (sx < sy) ? 32'd1 : 32'd0;
         C_AND:   r = x & y;
         C_LUI:   r = {y[15:0], 16'h0000};
         C_NOR:   r = ~(x | y);
         C_OR:    r = x | y;
         C_XOR:   r = x ^ y;
         C_SLL:   r = y << sh;
         C_SRA:   begin s = sy >>> sh; r = s[31:0]; end
         C_SRL:   r = y >> sh;
         C_SLTU:  r = (x < y) ? 32'd1 : 32'd0;
         C_MFHI:  r = m_hi;
         C_MFLO:  r = m_lo;
         default: r = 32'h0;
      endcase
      return {ov, r};
   endfunction

   function automatic void md_ref(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] hi, output logic [31:0] lo);
      longint sx, sy;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      hi = m_hi;
      lo = m_lo;
      case (f)
         C_MULT:  begin p = sx * sy; {hi, lo} = p; end
         C_MULTU: begin p = {32'h0, x} * {32'h0, y}; {hi, lo} = p; end
         C_DIV: begin
            if (y == 32'h0) begin lo = 32'hFFFFFFFF; hi = x; end
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin lo = 32'h80000000; hi = 32'h0; end
            else begin p = sx / sy; lo = p[31:0]; p = sx % sy; hi = p[31:0]; end
         end
         C_DIVU: begin
            if (y == 32'h0) begin lo = 32'hFFFFFFFF; hi = x; end
            else begin lo = x / y; hi = x % y; end
         end
         default: begin hi = m_hi; lo = m_lo; end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'(31'($urandom_range(0, 20)));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; op = C_ADD; a = 32'h0; b = 32'h0;
      #12;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      op = C_MFHI; #1;
      n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h expected 0", result); end
      op = C_MFLO; #1;
      n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h expected 0", result); end
      m_hi = 32'h0; m_lo = 32'h0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_alu_directed();
      logic [4:0]  t_op [8] = '{C_ADD, C_SUB, C_SRA, C_SRL, C_SLTU, C_SLT, C_LUI, 5'h1F};
      logic [31:0] t_a  [8] = '{32'h7FFFFFFF, 32'd5, 32'd31, 32'd31, 32'd1, 32'd1, 32'h0, 32'd5};
      logic [31:0] t_b  [8] = '{32'd1, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000ABCD, 32'd5};
      logic [31:0] t_r  [8] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 32'hABCD0000, 32'h0};
      logic        t_ov [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         op = t_op[i]; a = t_a[i]; b = t_b[i]; #2;
         n_cmp++; if (result !== t_r[i]) begin n_bad++; $display("FAIL dir_result[%0d]: got %h expected %h", i, result, t_r[i]); end
         n_cmp++; if (overflow !== t_ov[i]) begin n_bad++; $display("FAIL dir_overflow[%0d]: got %b expected %b", i, overflow, t_ov[i]); end
         n_cmp++; if (zero !== (t_r[i] == 32'h0)) begin n_bad++; $display("FAIL dir_zero[%0d]: got %b expected %b", i, zero, (t_r[i] == 32'h0)); end
      end
   endtask

   task automatic test_alu_random();
      logic [32:0] e;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         op = ($urandom_range(0, 7) == 0) ? 5'(5'h14 + $urandom_range(0, 11)) : 5'($urandom_range(0, 11));
         a = pick(); b = pick(); in_valid = 1'($urandom_range(0, 1));
         #3;
         e = alu_ref(op, a, b);
         n_cmp++; if (result !== e[31:0]) begin n_bad++; $display("FAIL rnd_result op=%h a=%h b=%h: got %h expected %h", op, a, b, result, e[31:0]); end
         n_cmp++; if (overflow !== e[32]) begin n_bad++; $display("FAIL rnd_overflow op=%h a=%h b=%h: got %b expected %b", op, a, b, overflow, e[32]); end
         n_cmp++; if (zero !== (e[31:0] == 32'h0)) begin n_bad++; $display("FAIL rnd_zero op=%h: got %b expected %b", op, zero, (e[31:0] == 32'h0)); end
      end
      @(posedge clk); #1; in_valid = 1'b0; op = C_MFHI; #1;
      n_cmp++; if (result !== m_hi) begin n_bad++; $display("FAIL rnd_hi_kept: got %h expected %h", result, m_hi); end
      op = C_MFLO; #1;
      n_cmp++; if (result !== m_lo) begin n_bad++; $display("FAIL rnd_lo_kept: got %h expected %h", result, m_lo); end
   endtask

   task automatic run_md(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y);
      int k, done_at, n_done;
      logic [31:0] eh, el;
      @(posedge clk); #1;
      op = f; a = x; b = y; in_valid = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL md_in_ready op=%h: got %b expected 1", f, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; op = C_ADD;
      k = 0; done_at = -1; n_done = 0;
      while (busy === 1'b1 && k < 200) begin
         if (done === 1'b1) begin n_done++; done_at = k; end
         k++;
         @(posedge clk); #1;
      end
      n_cmp++; if (k != W + 1) begin n_bad++; $display("FAIL md_busy_cycles op=%h: got %0d expected %0d", f, k, W + 1); end
      n_cmp++; if (n_done != 1 || done_at != W) begin n_bad++; $display("FAIL md_done_pulse op=%h: got %0d pulses at %0d expected 1 at %0d", f, n_done, done_at, W); end
      md_ref(f, x, y, eh, el);
      m_hi = eh; m_lo = el;
      op = C_MFHI; #1;
      n_cmp++; if (result !== eh) begin n_bad++; $display("FAIL md_hi op=%h a=%h b=%h: got %h expected %h", f, x, y, result, eh); end
      op = C_MFLO; #1;
      n_cmp++; if (result !== el) begin n_bad++; $display("FAIL md_lo op=%h a=%h b=%h: got %h expected %h", f, x, y, result, el); end
   endtask

   task automatic test_md_directed();
      run_md(C_MULT, 32'hFFFFFFFD, 32'd7);
      run_md(C_MULTU, 32'hFFFFFFFF, 32'd2);
      run_md(C_DIV, 32'hFFFFFFF9, 32'd2);
      run_md(C_DIVU, 32'd7, 32'd0);
      run_md(C_DIV, 32'h80000000, 32'hFFFFFFFF);
      run_md(C_DIV, 32'hFFFFFFF9, 32'd0);
   endtask

   task automatic test_md_random();
      for (int i = 0; i < 14; i++) begin
         run_md(5'(5'h0C + $urandom_range(0, 3)), pick(), pick());
      end
   endtask

   task automatic test_mt();
      logic [31:0] x, y;
      x = $urandom; y = $urandom;
      @(posedge clk); #1; op = C_MTHI; a = x; in_valid = 1'b1;
      @(posedge clk); #1; op = C_MTLO; a = y;
      #1; m_hi = x;
      @(posedge clk); #1; in_valid = 1'b0; op = C_MFHI; #1;
      m_lo = y;
      n_cmp++; if (result !== x) begin n_bad++; $display("FAIL mthi: got %h expected %h", result, x); end
      op = C_MFLO; #1;
      n_cmp++; if (result !== y) begin n_bad++; $display("FAIL mtlo: got %h expected %h", result, y); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x2, y2, eh, el;
      int k, n_stall_bad;
      x2 = $urandom; y2 = $urandom;
      @(posedge clk); #1; op = C_MULT; a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; op = C_MFHI; #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_mf_stall: got %b expected 1", stall); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready: got %b expected 0", in_ready); end
      n_cmp++; if (result !== m_hi) begin n_bad++; $display("FAIL b2b_old_hi: got %h expected %h", result, m_hi); end
      @(posedge clk); #1; op = C_MULT; a = x2; b = y2; in_valid = 1'b1;
      k = 0; n_stall_bad = 0;
      while (busy === 1'b1 && k < 200) begin
         if (stall !== 1'b1 || in_ready !== 1'b0) n_stall_bad++;
         k++;
         @(posedge clk); #1;
      end
      n_cmp++; if (n_stall_bad != 0 || k == 0) begin n_bad++; $display("FAIL b2b_hold_stall: got %0d bad of %0d cycles expected 0 bad", n_stall_bad, k); end
      n_cmp++; if (in_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: got in_ready=%b stall=%b expected 1 0", in_ready, stall); end
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got busy=%b expected 1", busy); end
      in_valid = 1'b0; op = C_ADD;
      k = 0;
      while (busy === 1'b1 && k < 200) begin k++; @(posedge clk); #1; end
      md_ref(C_MULT, x2, y2, eh, el);
      m_hi = eh; m_lo = el;
      op = C_MFHI; #1;
      n_cmp++; if (result !== eh) begin n_bad++; $display("FAIL b2b_hi: got %h expected %h", result, eh); end
      op = C_MFLO; #1;
      n_cmp++; if (result !== el) begin n_bad++; $display("FAIL b2b_lo: got %h expected %h", result, el); end
   endtask

   task automatic test_reset_mid_op();
      int n_evt;
      @(posedge clk); #1; op = C_DIV; a = $urandom; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; op = C_ADD;
      repeat (10) @(posedge clk);
      #3; rst_n = 1'b0; #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done: got %b expected 0", done); end
      op = C_MFHI; #1;
      n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL rst_mid_hi: got %h expected 0", result); end
      op = C_MFLO; #1;
      n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL rst_mid_lo: got %h expected 0", result); end
      m_hi = 32'h0; m_lo = 32'h0;
      @(negedge clk); rst_n = 1'b1;
      n_evt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) n_evt++;
      end
      n_cmp++; if (n_evt != 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d busy/done cycles expected 0", n_evt); end
      op = C_MTLO; a = 32'h1234; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; op = C_MFLO; #1;
      m_lo = 32'h1234;
      n_cmp++; if (result !== 32'h1234) begin n_bad++; $display("FAIL rst_mid_mtlo: got %h expected 00001234", result); end
   endtask

   initial begin
      test_reset();
      test_alu_directed();
      test_alu_random();
      test_md_directed();
      test_md_random();
      test_mt();
      test_back_to_back();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
